// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and defaults for the gated-clock domain controller.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_WAKE = 2'b01,
        S_ON   = 2'b10,
        S_HOLD = 2'b11
    } gate_state_t;

    localparam int DEFAULT_WAKE_CYCLES = 2;
    localparam int DEFAULT_HOLD_CYCLES = 4;

endpackage

// File: rtl/clk_gate_ctrl.sv
// Drives the enable of the latch-based clock gate: wake-up delay before grant,
// idle hysteresis before shutting the gated domain off again.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int WAKE_CYCLES = DEFAULT_WAKE_CYCLES,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int CNT_WIDTH   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic               FORCE_ON,
    output logic               CLK_EN,
    output logic [NUM_REQ-1:0] GNT,
    output logic               GATE_ON
);

    localparam logic [CNT_WIDTH-1:0] WAKE_LAST = CNT_WIDTH'(WAKE_CYCLES - 1);
    // HOLD_CYCLES==0 never reaches HOLD, so the terminal value is unused there
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
        CNT_WIDTH'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

    gate_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 any_req;

    assign any_req = (|REQ) | FORCE_ON;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            CLK_EN  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            CLK_EN  <= (state_d != S_OFF);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_OFF: begin
                if (any_req) begin
                    state_d = S_WAKE;
                    cnt_d   = '0;
                end
            end
            // wake runs to completion even if every request drops meanwhile
            S_WAKE: begin
                if (cnt_q == WAKE_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_ON: begin
                if (!any_req) begin
                    state_d = (HOLD_CYCLES == 0) ? S_OFF : S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (any_req) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    assign GATE_ON = (state_q == S_ON);
    assign GNT     = REQ & {NUM_REQ{GATE_ON}};

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: fixed vector table, corner sequences, then random traffic vs. a timer model.
module tb_clk_gate_ctrl;

    localparam int NUM_REQ     = 2;
    localparam int WAKE_CYCLES = 2;
    localparam int HOLD_CYCLES = 4;

    logic               CLK;
    logic               RST;
    logic [NUM_REQ-1:0] REQ;
    logic               FORCE_ON;
    logic               CLK_EN;
    logic [NUM_REQ-1:0] GNT;
    logic               GATE_ON;

    clk_gate_ctrl #(
        .NUM_REQ(NUM_REQ), .WAKE_CYCLES(WAKE_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES), .CNT_WIDTH(4)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .FORCE_ON(FORCE_ON),
        .CLK_EN(CLK_EN), .GNT(GNT), .GATE_ON(GATE_ON)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: gate powered, remaining wake edges, consecutive idle edges since last demand.
    bit m_pw;
    int m_wake;
    int m_idle;

    function automatic bit m_on();
        return m_pw && (m_wake == 0) && (m_idle == 0);
    endfunction

    task automatic model_reset();
        m_pw = 0; m_wake = 0; m_idle = 0;
    endtask

    task automatic model_edge(input bit demand);
        if (!m_pw) begin
            if (demand) begin
                m_pw = 1; m_wake = WAKE_CYCLES; m_idle = 0;
            end
        end else if (m_wake > 0) begin
            m_wake--;
        end else begin
            m_idle = demand ? 0 : m_idle + 1;
            if (m_idle > HOLD_CYCLES) begin
                m_pw = 0; m_idle = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".clk_en"},  32'(CLK_EN),  32'(m_pw));
        check({tag, ".gnt"},     32'(GNT),     32'(REQ & {NUM_REQ{m_on()}}));
        check({tag, ".gate_on"}, 32'(GATE_ON), 32'(m_on()));
    endtask

    // Drive inputs mid-cycle, take one rising edge, settle before sampling.
    task automatic step(input logic r, input logic [NUM_REQ-1:0] q, input logic f);
        RST = r; REQ = q; FORCE_ON = f;
        if (!r) model_reset();
        @(posedge CLK);
        if (!RST) model_reset();
        else model_edge((|REQ) | FORCE_ON);
        #1;
    endtask

    typedef struct {
        logic               rst;
        logic [NUM_REQ-1:0] req;
        logic               frc;
        logic               en;
        logic [NUM_REQ-1:0] gnt;
        logic               gate;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic r, input logic [1:0] q, input logic f,
                     input logic e, input logic [1:0] g, input logic o);
        vec_t t;
        t.rst = r; t.req = q; t.frc = f; t.en = e; t.gnt = g; t.gate = o;
        tbl.push_back(t);
    endtask

    initial begin
        logic [NUM_REQ-1:0] rq;
        logic               rf;
        int                 run;

        RST = 1'b0; REQ = '0; FORCE_ON = 1'b0;
        model_reset();

        // reset held with demand, release, wake, grant, hold, off
        v(0,2'b11,0, 0,2'b00,0); v(0,2'b11,0, 0,2'b00,0);
        v(1,2'b11,0, 1,2'b00,0); v(1,2'b11,0, 1,2'b00,0); v(1,2'b11,0, 1,2'b11,1);
        v(1,2'b00,0, 1,2'b00,0); v(1,2'b00,0, 1,2'b00,0); v(1,2'b00,0, 1,2'b00,0);
        v(1,2'b00,0, 1,2'b00,0); v(1,2'b00,0, 0,2'b00,0); v(1,2'b00,0, 0,2'b00,0);
        // single request lifecycle: 5 cycles high, granted in cycles 3-5
        v(1,2'b01,0, 1,2'b00,0); v(1,2'b01,0, 1,2'b00,0); v(1,2'b01,0, 1,2'b01,1);
        v(1,2'b01,0, 1,2'b01,1); v(1,2'b01,0, 1,2'b01,1);
        v(1,2'b00,0, 1,2'b00,0); v(1,2'b00,0, 1,2'b00,0); v(1,2'b00,0, 1,2'b00,0);
        v(1,2'b00,0, 1,2'b00,0); v(1,2'b00,0, 0,2'b00,0);
        // hold re-entry without re-wake
        v(1,2'b10,0, 1,2'b00,0); v(1,2'b10,0, 1,2'b00,0); v(1,2'b10,0, 1,2'b10,1);
        v(1,2'b00,0, 1,2'b00,0); v(1,2'b00,0, 1,2'b00,0); v(1,2'b10,0, 1,2'b10,1);
        // handover between requesters on one edge keeps ON
        v(1,2'b01,0, 1,2'b01,1); v(1,2'b10,0, 1,2'b10,1);
        v(1,2'b00,0, 1,2'b00,0); v(1,2'b00,0, 1,2'b00,0); v(1,2'b00,0, 1,2'b00,0);
        v(1,2'b00,0, 1,2'b00,0); v(1,2'b00,0, 0,2'b00,0);
        // FORCE_ON alone: full wake, ON status, no grants
        v(1,2'b00,1, 1,2'b00,0); v(1,2'b00,1, 1,2'b00,0); v(1,2'b00,1, 1,2'b00,1);
        v(1,2'b00,1, 1,2'b00,1);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].frc);
            check($sformatf("vec%0d.clk_en", i),  32'(CLK_EN),  32'(tbl[i].en));
            check($sformatf("vec%0d.gnt", i),     32'(GNT),     32'(tbl[i].gnt));
            check($sformatf("vec%0d.gate_on", i), 32'(GATE_ON), 32'(tbl[i].gate));
        end

        // request under FORCE_ON is granted combinationally in the same cycle
        REQ = 2'b10;
        #1;
        check("force.same_cycle_gnt", 32'(GNT), 32'(2'b10));

        // drop everything, reach hold cnt=2, then async reset mid-cycle
        step(1, 2'b00, 0); check_model("hold0");
        check("hold0.clk_en_abs", 32'(CLK_EN), 32'd1);
        step(1, 2'b00, 0); check_model("hold1");
        step(1, 2'b00, 0); check_model("hold2");
        RST = 1'b0;
        model_reset();
        #1;
        check("areset.clk_en", 32'(CLK_EN), 32'd0);
        check("areset.gate_on", 32'(GATE_ON), 32'd0);
        step(0, 2'b01, 0); check_model("areset.held");
        step(1, 2'b01, 0); check_model("rewake0");
        step(1, 2'b01, 0); check_model("rewake1");
        check("rewake1.no_gnt", 32'(GNT), 32'd0);
        step(1, 2'b01, 0); check_model("rewake2");
        check("rewake2.gnt", 32'(GNT), 32'(2'b01));

        // random traffic with run lengths that straddle the wake and hold windows
        run = 0; rq = '0; rf = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (run == 0) begin
                rq  = NUM_REQ'($urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) rq = '0;
                rf  = ($urandom_range(0, 7) == 0);
                run = $urandom_range(1, 8);
            end
            run--;
            if ($urandom_range(0, 59) == 0) begin
                RST = 1'b0;
                model_reset();
                #1;
                check_model("rnd.areset");
                step(0, rq, rf);
                check_model("rnd.inreset");
            end
            step(1, rq, rf);
            check_model("rnd");
            if ($urandom_range(0, 9) == 0) begin
                REQ = NUM_REQ'($urandom_range(0, 3));
                #1;
                check("rnd.comb_gnt", 32'(GNT), 32'(REQ & {NUM_REQ{m_on()}}));
                REQ = rq;
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Clock-gating controller that decides when the gated clock domain (ALU and similar on-demand datapaths) receives clock. It collects requests from several requesters and drives the enable of the latch-based clock gate cell. It provides a wake-up delay before granting, and an idle hysteresis so short gaps between requests do not toggle the gate. It sits in the reference-clock domain of the system top level, directly beside the clock gate instance it controls.

## Interface
- NUM_REQ, 2, number of requesters (1..8)
- WAKE_CYCLES, 2, cycles from gate enable to first grant (1..15)
- HOLD_CYCLES, 4, idle cycles gate stays enabled after last request drops (0..15)
- CNT_WIDTH, 4, width of internal wake/hold counter; must hold max(WAKE_CYCLES, HOLD_CYCLES)

- CLK  input  1  ungated reference clock; all state updates on rising edge
- RST  input  1  asynchronous active-low reset
- REQ  input  NUM_REQ  per-requester demand for gated clock; level, held until own GNT seen and work done
- FORCE_ON  input  1  config/DFT override; behaves as a request that never receives a grant
- CLK_EN  output  1  registered enable to clock gate cell
- GNT  output  NUM_REQ  per-requester grant; gated clock guaranteed running while asserted
- GATE_ON  output  1  status: state is ON

## Operation
- States: OFF, WAKE, ON, HOLD. Counter `cnt` (CNT_WIDTH bits) shared by WAKE and HOLD.
- any_req = |REQ or FORCE_ON.
- OFF: CLK_EN=0. any_req → WAKE, cnt←0.
- WAKE: CLK_EN=1. cnt increments each cycle. cnt==WAKE_CYCLES-1 → ON. Wake never aborts; requests dropping during WAKE do not shorten it.
- ON: CLK_EN=1. any_req=0 → HOLD with cnt←0, or → OFF directly if HOLD_CYCLES==0.
- HOLD: CLK_EN=1. any_req=1 → ON (no re-wake). Else cnt==HOLD_CYCLES-1 → OFF. Otherwise cnt increments.
- GNT[i] = REQ[i] & (state==ON). This is combinational from registered state; no priority or exclusivity. All requesters share the running clock.
- GATE_ON = (state==ON).
- CLK_EN is the registered decode of next state, so it is 1 in WAKE, ON and HOLD, and 0 only in OFF.
- Reset (any time, including mid-WAKE or mid-HOLD): state=OFF, cnt=0, CLK_EN=0, GNT=0, GATE_ON=0.
  - Async deassertion of CLK_EN is safe because the gate cell samples enable only during CLK low.

## Timing
- REQ sampled high at edge t in OFF:
  - CLK_EN=1 after edge t.
  - Gate cell latches it during the following low phase; first gated pulse at edge t+1.
  - State ON after edge t+WAKE_CYCLES; GNT high in that cycle if REQ still high.
- Last request drops (sampled at edge t, in ON):
  - HOLD after t.
  - OFF after edge t+HOLD_CYCLES.
  - CLK_EN falls after that same edge.
- Request reasserted during HOLD at edge t: ON after t, GNT in the next cycle. Latency 1 cycle vs WAKE_CYCLES from OFF.
- New request while ON: GNT in the same cycle, combinationally.
- Simultaneous drop of one REQ and rise of another in ON: any_req stays 1, remain ON.
- FORCE_ON alone: follows the full OFF→WAKE→ON path with GNT=0 and GATE_ON=1. Dropping it follows the HOLD path.

## Structure
- Package clk_gate_ctrl_pkg:
  - state encoding OFF=2'b00, WAKE=2'b01, ON=2'b10, HOLD=2'b11
  - localparam defaults for WAKE_CYCLES and HOLD_CYCLES
- No sub-module: the FSM, counter and output decode are one module.
- The top level instantiates it next to the existing clock gate instance, with CLK_EN wired to that gate's enable.

## Test plan
- Reset: hold RST=0 with REQ=2'b11 → CLK_EN=0, GNT=0, GATE_ON=0. Release RST → CLK_EN=1 one edge later, GNT=2'b11 two edges after that (WAKE_CYCLES=2).
- Single request lifecycle: REQ[0] high 5 cycles then low → GNT[0] high for cycles 3–5. CLK_EN stays 1 for 4 cycles after the drop (HOLD_CYCLES=4), then 0.
- Hold re-entry: drop REQ, reassert at hold cycle 2 → no WAKE, GNT one cycle after reassert, CLK_EN never drops.
- Overlap: REQ[0] low and REQ[1] high on the same edge while ON → state stays ON, GNT tracks REQ exactly, no HOLD entry.
- FORCE_ON: FORCE_ON=1, REQ=0 → CLK_EN=1, GATE_ON=1 after wake, GNT=0 throughout. Then REQ[1]=1 → GNT[1]=1 the same cycle.
- Async reset mid-HOLD (cnt=2) → CLK_EN=0 immediately, state OFF. The next request takes the full WAKE_CYCLES again.
